vie_mem_stage_ls: RTL and testbench
===================================

Name: vie_mem_stage_ls

Overview:
Parametrised MEM pipeline stage for the vie MIPS core that drives the data-memory request itself, replacing the fixed-latency, always-ready memory stage.
- Issues load/store requests on a req/addr_ok/data_ok bus and tolerates variable response latency.
- Aligns and sign/zero-extends sub-word loads.
- Supports flush, discarding any in-flight response.
- Sits between the EXE-side result bus and the WB stage, and exports forwarding/hazard status.

Parameters:
DEST_W, 7, width of destination-register tag.
PC_W, 32, width of PC field.

Ports:
clock  in  1  clock.
reset  in  1  reset, synchronous, active-high.
flush  in  1  discard stage contents and any outstanding response.
in_valid  in  1  upstream instruction valid.
in_op  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9-15 treated as none.
in_dest  in  DEST_W  destination tag (0 = no write).
in_addr  in  32  effective address.
in_wdata  in  32  store data (low bits valid).
in_fixres  in  32  ALU result for non-load ops.
in_pc  in  PC_W  instruction PC.
ms_allowin  out  1  stage can accept in this cycle.
ws_allowin  in  1  WB can accept.
out_valid  out  1  result valid to WB.
out_dest  out  DEST_W  destination tag.
out_pc  out  PC_W  PC.
out_res  out  32  final result.
data_req  out  1  memory request.
data_wr  out  1  1=store.
data_size  out  2  0=byte, 1=half, 2=word.
data_addr  out  32  request address.
data_wstrb  out  4  byte strobes (0 for loads).
data_wdata  out  32  lane-replicated store data.
data_addr_ok  in  1  request accepted.
data_rdata  in  32  read data.
data_data_ok  in  1  response valid (one per accepted request, in order).
status_valid  out  1  stage holds valid instruction.
status_dest  out  DEST_W  tag for forwarding.
status_res  out  32  equals out_res.
status_stall  out  1  load result not yet available (ID must stall dependants).

Behaviour:
- Reset: all outputs 0, ms_valid=0, state=IDLE, cancel=0. ms_allowin=1 after reset.
- Capture: when in_valid && ms_allowin, register all in_* fields.
  - ms_valid <= in_valid whenever ms_allowin.
  - flush clears ms_valid, with priority over capture.
- State machine:
  - IDLE: captured mem op (1-8) -> REQ.
  - REQ: data_req = (cancel==0). On data_req && data_addr_ok -> WAIT.
  - WAIT: on data_data_ok with cancel==0, capture extended load data -> DONE.
  - DONE: on stage advance -> IDLE, or directly REQ if the newly captured op is a mem op.
  - A non-mem op in IDLE is immediately done.
- ms_cango = ms_valid && (op is none || state==DONE || (state==WAIT && data_data_ok && cancel==0)).
  - Same-cycle data_ok bypasses: out_res uses live data_rdata.
  - Minimum latency, entry to out_valid for a mem op: 2 cycles with addr_ok and data_ok each returned in the first cycle offered.
- Handshake:
  - ms_allowin = !ms_valid || (ms_cango && ws_allowin).
  - out_valid = ms_cango.
- Request fields:
  - data_addr = addr; data_size from op.
  - Store strobes from addr[1:0]: SB 4'b0001<<addr[1:0]; SH 4'b0011 or 4'b1100 by addr[1]; SW 4'b1111.
  - Store data replication: SB {4{b}}, SH {2{h}}.
  - Misalignment is not checked here.
- Load extension:
  - Byte lane = addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - Half selected by addr[1]; LW passes through.
- Stores: result is in_fixres, but the stage still waits for data_ok before cango.
- Flush in WAIT, or in REQ with addr_ok the same cycle: cancel <= 1, state -> IDLE.
  - Next data_ok with cancel==1 is dropped and clears cancel.
  - A new request is not issued while cancel==1 (data_req held 0 in REQ); inputs are still accepted.
- Flush in REQ without addr_ok: request withdrawn next cycle, cancel unchanged.
- Simultaneous flush and data_ok in WAIT: response consumed and dropped; cancel stays 0.
- status_stall = ms_valid && op in 1..5 && !ms_cango.
- At most one request outstanding, so cancel is one bit.

Test Plan:
1. LW addr 0x100, addr_ok and data_ok immediate, rdata 0x89ABCDEF -> out_valid 2 cycles after capture, out_res 0x89ABCDEF, data_wstrb 0.
2. LB/LBU addr 0x103, rdata 0x80123456 -> LB res 0xFFFFFF80, LBU res 0x00000080. LH addr 0x102 -> 0xFFFF8012.
3. SH addr 0x2, wdata 0x1234 -> data_wr=1, size=1, wstrb 4'b1100, wdata 0x12341234. out_res = fixres after data_ok.
4. LW with data_ok delayed 5 cycles -> status_stall=1 and ms_allowin=0 throughout; ws_allowin=0 at completion holds out_valid/out_res stable.
5. Flush in WAIT, next LW captured, stale data_ok 0xDEAD arrives -> dropped, no data_req until it returns, then new request issued and its data returned.
6. Reset asserted mid-WAIT -> all outputs 0, state IDLE, cancel 0 next cycle.

Source files
------------

// File: rtl/vie_mem_stage_ls.sv
// MEM stage for the vie core: issues load/store requests on a req/addr_ok/data_ok
// bus, tolerates variable response latency, and extends sub-word loads.
module vie_mem_stage_ls #(
  parameter int DEST_W = 7,
  parameter int PC_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_fixres,
  input  logic [PC_W-1:0]   in_pc,
  output logic              ms_allowin,
  input  logic              ws_allowin,
  output logic              out_valid,
  output logic [DEST_W-1:0] out_dest,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_res,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic [31:0]       data_rdata,
  input  logic              data_data_ok,
  output logic              status_valid,
  output logic [DEST_W-1:0] status_dest,
  output logic [31:0]       status_res,
  output logic              status_stall
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_e              state_q, state_d;
  logic                ms_valid_q, ms_valid_d;
  logic                cancel_q, cancel_d;
  logic [3:0]          op_q;
  logic [DEST_W-1:0]   dest_q;
  logic [31:0]         addr_q, wdata_q, fixres_q, ldres_q;
  logic [PC_W-1:0]     pc_q;

  logic is_load, is_store, is_mem, in_is_mem;
  logic ms_cango, advance, capture, ld_en;
  logic [31:0] ld_live;

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lo +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'd0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'd0, h};
      default: load_ext = rdata;
    endcase
  endfunction

  assign is_load   = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign is_store  = (op_q >= OP_SB) && (op_q <= OP_SW);
  assign is_mem    = is_load || is_store;
  assign in_is_mem = (in_op >= OP_LB) && (in_op <= OP_SW);
  assign ld_live   = load_ext(op_q, addr_q[1:0], data_rdata);

  assign data_req   = ms_valid_q && (state_q == S_REQ) && !cancel_q;
  assign ms_cango   = ms_valid_q && (!is_mem || state_q == S_DONE ||
                      (state_q == S_WAIT && data_data_ok && !cancel_q));
  assign advance    = ms_cango && ws_allowin;
  assign ms_allowin = !ms_valid_q || advance;
  assign capture    = in_valid && ms_allowin && !flush;

  always_comb begin
    ms_valid_d = ms_valid_q;
    state_d    = state_q;
    cancel_d   = cancel_q;
    ld_en      = 1'b0;
    if (ms_allowin) ms_valid_d = in_valid;
    if (flush) ms_valid_d = 1'b0;
    case (state_q)
      S_REQ:  if (data_req && data_addr_ok) state_d = S_WAIT;
      S_WAIT: if (data_data_ok && !cancel_q) begin
        state_d = S_DONE;
        ld_en   = 1'b1;
      end
      default: ;
    endcase
    if (advance) state_d = S_IDLE;
    if (capture && in_is_mem) state_d = S_REQ;
    if (cancel_q && data_data_ok) cancel_d = 1'b0;
    // An accepted-but-unanswered request must have its response swallowed later.
    if (flush) begin
      state_d = S_IDLE;
      if ((state_q == S_WAIT && !data_data_ok) ||
          (state_q == S_REQ && data_req && data_addr_ok))
        cancel_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ms_valid_q <= 1'b0;
      cancel_q   <= 1'b0;
      op_q       <= '0;
      dest_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fixres_q   <= '0;
      pc_q       <= '0;
      ldres_q    <= '0;
    end else begin
      state_q    <= state_d;
      ms_valid_q <= ms_valid_d;
      cancel_q   <= cancel_d;
      if (capture) begin
        op_q     <= in_op;
        dest_q   <= in_dest;
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
        fixres_q <= in_fixres;
        pc_q     <= in_pc;
      end
      if (ld_en) ldres_q <= ld_live;
    end
  end

  always_comb begin
    data_size  = 2'd0;
    data_wstrb = 4'b0000;
    data_wdata = 32'd0;
    case (op_q)
      OP_LH, OP_LHU: data_size = 2'd1;
      OP_LW:         data_size = 2'd2;
      OP_SB: begin
        data_wstrb = 4'b0001 << addr_q[1:0];
        data_wdata = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        data_size  = 2'd1;
        data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{wdata_q[15:0]}};
      end
      OP_SW: begin
        data_size  = 2'd2;
        data_wstrb = 4'b1111;
        data_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Same-cycle data_ok bypasses the load register so the result leaves immediately.
  always_comb begin
    out_res = fixres_q;
    if (is_load) out_res = (state_q == S_DONE) ? ldres_q : ld_live;
  end

  assign data_wr      = is_store;
  assign data_addr    = addr_q;
  assign out_valid    = ms_cango;
  assign out_dest     = dest_q;
  assign out_pc       = pc_q;
  assign status_valid = ms_valid_q;
  assign status_dest  = dest_q;
  assign status_res   = out_res;
  assign status_stall = ms_valid_q && is_load && !ms_cango;

endmodule

// File: tb/tb_vie_mem_stage_ls.sv
// Directed bench for vie_mem_stage_ls: loads, stores, stalls, flush-cancel and reset.
module tb_vie_mem_stage_ls;
  localparam int DEST_W = 7;
  localparam int PC_W   = 32;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, ws_allowin;
  logic [3:0]        in_op;
  logic [DEST_W-1:0] in_dest;
  logic [31:0]       in_addr, in_wdata, in_fixres;
  logic [PC_W-1:0]   in_pc;
  logic              ms_allowin, out_valid;
  logic [DEST_W-1:0] out_dest, status_dest;
  logic [PC_W-1:0]   out_pc;
  logic [31:0]       out_res, status_res;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [31:0]       data_addr, data_wdata, data_rdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok, data_data_ok;
  logic              status_valid, status_stall;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  vie_mem_stage_ls #(.DEST_W(DEST_W), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_dest(in_dest), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_fixres(in_fixres), .in_pc(in_pc),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .out_valid(out_valid), .out_dest(out_dest), .out_pc(out_pc), .out_res(out_res),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .status_valid(status_valid), .status_dest(status_dest), .status_res(status_res),
    .status_stall(status_stall)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] fixres, input logic [DEST_W-1:0] dest,
                       input logic [PC_W-1:0] pc);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
    in_fixres = fixres; in_dest = dest; in_pc = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_dest = '0;
    in_addr = 32'd0; in_wdata = 32'd0; in_fixres = 32'd0; in_pc = '0;
    ws_allowin = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    step(); step();
    reset = 1'b0;
    #1;
    tests_run++;
    if (ms_allowin !== 1'b1) begin tests_failed++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
    tests_run++;
    if ({out_valid, data_req, status_valid, status_stall, data_wr} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 00000", {out_valid, data_req, status_valid, status_stall, data_wr});
    end
    tests_run++;
    if ({out_res, data_addr, data_wdata, data_wstrb} !== 100'd0) begin
      tests_failed++; $display("FAIL reset_data: got res=%h addr=%h wdata=%h wstrb=%b expected all 0", out_res, data_addr, data_wdata, data_wstrb);
    end
  endtask

  task automatic test_lw_basic();
    issue(4'd5, 32'h100, 32'd0, 32'd0, 7'd3, 32'hBFC00010);
    #1;
    tests_run++;
    if (ms_allowin !== 1'b1) begin tests_failed++; $display("FAIL lw_allowin: got %b expected 1", ms_allowin); end
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if ({data_req, data_wr, data_size, data_wstrb, out_valid, status_stall} !== {1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b1}) begin
      tests_failed++; $display("FAIL lw_req: got req=%b wr=%b size=%0d wstrb=%b ov=%b stall=%b expected 1 0 2 0000 0 1",
                               data_req, data_wr, data_size, data_wstrb, out_valid, status_stall);
    end
    tests_run++;
    if (data_addr !== 32'h100) begin tests_failed++; $display("FAIL lw_addr: got %h expected 00000100", data_addr); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h89ABCDEF;
    #1;
    tests_run++;
    if ({out_valid, out_res, out_dest, out_pc} !== {1'b1, 32'h89ABCDEF, 7'd3, 32'hBFC00010}) begin
      tests_failed++; $display("FAIL lw_result: got ov=%b res=%h dest=%0d pc=%h expected 1 89abcdef 3 bfc00010",
                               out_valid, out_res, out_dest, out_pc);
    end
    tests_run++;
    if (status_res !== 32'h89ABCDEF || status_stall !== 1'b0) begin
      tests_failed++; $display("FAIL lw_status: got res=%h stall=%b expected 89abcdef 0", status_res, status_stall);
    end
    step();
    data_data_ok = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || status_valid !== 1'b0) begin
      tests_failed++; $display("FAIL lw_retire: got ov=%b sv=%b expected 0 0", out_valid, status_valid);
    end
  endtask

  task automatic do_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [1:0] size, input logic [31:0] expected);
    issue(op, addr, 32'd0, 32'd0, 7'd4, 32'h40);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if (data_req !== 1'b1 || data_size !== size) begin
      tests_failed++; $display("FAIL %s_req: got req=%b size=%0d expected 1 %0d", name, data_req, data_size, size);
    end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_res !== expected) begin
      tests_failed++; $display("FAIL %s_res: got ov=%b res=%h expected 1 %h", name, out_valid, out_res, expected);
    end
    step();
    data_data_ok = 1'b0;
  endtask

  task automatic test_subword_loads();
    do_load("lb",  4'd1, 32'h103, 32'h80123456, 2'd0, 32'hFFFFFF80);
    do_load("lbu", 4'd2, 32'h103, 32'h80123456, 2'd0, 32'h00000080);
    do_load("lh",  4'd3, 32'h102, 32'h80123456, 2'd1, 32'hFFFF8012);
    do_load("lhu", 4'd4, 32'h102, 32'h80123456, 2'd1, 32'h00008012);
    do_load("lb0", 4'd1, 32'h100, 32'h80123456, 2'd0, 32'h00000056);
    do_load("lh0", 4'd3, 32'h100, 32'h0000F234, 2'd1, 32'hFFFFF234);
  endtask

  task automatic test_store();
    issue(4'd7, 32'h2, 32'h00001234, 32'hCAFE0001, 7'd0, 32'h80);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if ({data_req, data_wr, data_size, data_wstrb} !== {1'b1, 1'b1, 2'd1, 4'b1100}) begin
      tests_failed++; $display("FAIL sh_req: got req=%b wr=%b size=%0d wstrb=%b expected 1 1 1 1100", data_req, data_wr, data_size, data_wstrb);
    end
    tests_run++;
    if (data_wdata !== 32'h12341234) begin tests_failed++; $display("FAIL sh_wdata: got %h expected 12341234", data_wdata); end
    step();
    data_addr_ok = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || status_stall !== 1'b0) begin
      tests_failed++; $display("FAIL sh_wait: got ov=%b stall=%b expected 0 0", out_valid, status_stall);
    end
    step();
    data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_res !== 32'hCAFE0001) begin
      tests_failed++; $display("FAIL sh_res: got ov=%b res=%h expected 1 cafe0001", out_valid, out_res);
    end
    step();
    data_data_ok = 1'b0;
    issue(4'd6, 32'h1, 32'h00003456, 32'h1, 7'd0, 32'h84);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if ({data_req, data_wr, data_size, data_wstrb, data_wdata} !== {1'b1, 1'b1, 2'd0, 4'b0010, 32'h56565656}) begin
      tests_failed++; $display("FAIL sb_req: got req=%b wr=%b size=%0d wstrb=%b wdata=%h expected 1 1 0 0010 56565656",
                               data_req, data_wr, data_size, data_wstrb, data_wdata);
    end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    issue(4'd8, 32'h8, 32'hA5A5C3C3, 32'h2, 7'd0, 32'h88);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if ({data_wstrb, data_size, data_wdata} !== {4'b1111, 2'd2, 32'hA5A5C3C3}) begin
      tests_failed++; $display("FAIL sw_req: got wstrb=%b size=%0d wdata=%h expected 1111 2 a5a5c3c3", data_wstrb, data_size, data_wdata);
    end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
  endtask

  task automatic test_nonmem();
    issue(4'd0, 32'h0, 32'd0, 32'h00000077, 7'd5, 32'hC0);
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, data_req, status_stall, out_res, status_dest} !== {1'b1, 1'b0, 1'b0, 32'h77, 7'd5}) begin
      tests_failed++; $display("FAIL alu_pass: got ov=%b req=%b stall=%b res=%h dest=%0d expected 1 0 0 00000077 5",
                               out_valid, data_req, status_stall, out_res, status_dest);
    end
    issue(4'd12, 32'h0, 32'd0, 32'h00000099, 7'd6, 32'hC4);
    step();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, data_req, out_res} !== {1'b1, 1'b0, 32'h99}) begin
      tests_failed++; $display("FAIL op12_none: got ov=%b req=%b res=%h expected 1 0 00000099", out_valid, data_req, out_res);
    end
    step();
  endtask

  task automatic test_stall();
    issue(4'd5, 32'h140, 32'd0, 32'd0, 7'd8, 32'h100);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (status_stall !== 1'b1 || ms_allowin !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL stall_wait%0d: got stall=%b allowin=%b ov=%b expected 1 0 0", i, status_stall, ms_allowin, out_valid);
      end
      step();
    end
    ws_allowin = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11223344;
    #1;
    tests_run++;
    if ({out_valid, ms_allowin, out_res} !== {1'b1, 1'b0, 32'h11223344}) begin
      tests_failed++; $display("FAIL stall_done: got ov=%b allowin=%b res=%h expected 1 0 11223344", out_valid, ms_allowin, out_res);
    end
    step();
    data_data_ok = 1'b0; data_rdata = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if ({out_valid, out_res, status_stall, ms_allowin} !== {1'b1, 32'h11223344, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL stall_hold: got ov=%b res=%h stall=%b allowin=%b expected 1 11223344 0 0",
                               out_valid, out_res, status_stall, ms_allowin);
    end
    step();
    ws_allowin = 1'b1;
    #1;
    tests_run++;
    if (ms_allowin !== 1'b1 || out_res !== 32'h11223344) begin
      tests_failed++; $display("FAIL stall_release: got allowin=%b res=%h expected 1 11223344", ms_allowin, out_res);
    end
    step();
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_retire: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    issue(4'd5, 32'h200, 32'd0, 32'd0, 7'd10, 32'h200);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hAAAA0001;
    issue(4'd5, 32'h204, 32'd0, 32'd0, 7'd11, 32'h204);
    #1;
    tests_run++;
    if ({ms_allowin, out_valid, out_res} !== {1'b1, 1'b1, 32'hAAAA0001}) begin
      tests_failed++; $display("FAIL b2b_first: got allowin=%b ov=%b res=%h expected 1 1 aaaa0001", ms_allowin, out_valid, out_res);
    end
    step();
    in_valid = 1'b0; data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if (data_req !== 1'b1 || data_addr !== 32'h204) begin
      tests_failed++; $display("FAIL b2b_req: got req=%b addr=%h expected 1 00000204", data_req, data_addr);
    end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBBBB0002;
    #1;
    tests_run++;
    if ({out_valid, out_res, out_dest} !== {1'b1, 32'hBBBB0002, 7'd11}) begin
      tests_failed++; $display("FAIL b2b_second: got ov=%b res=%h dest=%0d expected 1 bbbb0002 11", out_valid, out_res, out_dest);
    end
    step();
    data_data_ok = 1'b0;
  endtask

  task automatic test_flush();
    issue(4'd5, 32'h180, 32'd0, 32'd0, 7'd12, 32'h300);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    issue(4'd5, 32'h280, 32'd0, 32'd0, 7'd13, 32'h304);
    #1;
    tests_run++;
    if ({ms_allowin, status_valid, out_valid} !== 3'b100) begin
      tests_failed++; $display("FAIL flush_clear: got allowin=%b sv=%b ov=%b expected 1 0 0", ms_allowin, status_valid, out_valid);
    end
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if (data_req !== 1'b0 || status_stall !== 1'b1) begin
      tests_failed++; $display("FAIL flush_noreq: got req=%b stall=%b expected 0 1", data_req, status_stall);
    end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000DEAD;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || data_req !== 1'b0) begin
      tests_failed++; $display("FAIL flush_stale: got ov=%b req=%b expected 0 0", out_valid, data_req);
    end
    step();
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if (data_req !== 1'b1 || data_addr !== 32'h280) begin
      tests_failed++; $display("FAIL flush_reissue: got req=%b addr=%h expected 1 00000280", data_req, data_addr);
    end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555AAAA;
    #1;
    tests_run++;
    if ({out_valid, out_res, out_dest} !== {1'b1, 32'h5555AAAA, 7'd13}) begin
      tests_failed++; $display("FAIL flush_newdata: got ov=%b res=%h dest=%0d expected 1 5555aaaa 13", out_valid, out_res, out_dest);
    end
    step();
    data_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    issue(4'd5, 32'h300, 32'd0, 32'h5, 7'd9, 32'h400);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, data_req, status_valid, status_stall, ms_allowin} !== 5'b00001) begin
      tests_failed++; $display("FAIL rst_mid_flags: got ov=%b req=%b sv=%b stall=%b allowin=%b expected 0 0 0 0 1",
                               out_valid, data_req, status_valid, status_stall, ms_allowin);
    end
    tests_run++;
    if ({out_dest, out_pc, out_res, data_addr} !== {7'd0, 32'd0, 32'd0, 32'd0}) begin
      tests_failed++; $display("FAIL rst_mid_data: got dest=%0d pc=%h res=%h addr=%h expected all 0", out_dest, out_pc, out_res, data_addr);
    end
    issue(4'd5, 32'h304, 32'd0, 32'd0, 7'd2, 32'h408);
    step();
    in_valid = 1'b0; data_addr_ok = 1'b1;
    #1;
    tests_run++;
    if (data_req !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_cancel: got req=%b expected 1", data_req); end
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h13579BDF;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_res !== 32'h13579BDF) begin
      tests_failed++; $display("FAIL rst_mid_after: got ov=%b res=%h expected 1 13579bdf", out_valid, out_res);
    end
    step();
    data_data_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_subword_loads();
    test_store();
    test_nonmem();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
